potential_decay_array: RTL
==========================

# potential_decay_array

Parametrised, multi-neuron membrane-potential decay engine for the SNN accelerator; successor to the single-neuron decay block. Holds NUM_NEURONS IEEE-754 single-precision potentials with per-neuron decay codes. On each timestep tick it sweeps every neuron, applies the exponent-shift or 0.75x decay, writes the result back and streams it downstream. It sits between the potential adder (update port) and the spike/threshold stage (output stream).

## Interface
- NUM_NEURONS, 10: number of neurons held (≥2)
- ADDR_W, $clog2(NUM_NEURONS): neuron index width
- RESET_RATE, 4'b0010: decay code loaded into every neuron at reset
- CLK  input  1  single clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- tick  input  1  timestep pulse; starts a sweep
- cfg_we  input  1  write rate and initial potential for cfg_addr
- cfg_addr  input  ADDR_W  neuron index for cfg_we
- cfg_rate  input  4  decay code
- cfg_pot  input  32  initial potential
- upd_valid  input  1  adder writes a new potential
- upd_addr  input  ADDR_W  neuron index for upd_valid
- upd_data  input  32  new potential
- in_ready  output  1  high in IDLE; cfg_we and upd_valid are ignored while low
- out_valid  output  1  decayed potential available
- out_ready  input  1  downstream accepts
- out_addr  output  ADDR_W  neuron index of out_data
- out_data  output  32  decayed potential
- busy  output  1  sweep in progress
- sweep_done  output  1  one-cycle pulse at end of sweep
- tick_overrun  output  1  sticky; tick arrived while busy

## Operation
- FSM: IDLE → SWEEP → DRAIN → IDLE.
- IDLE: accept cfg_we, then upd_valid; if both target the same address in one cycle, upd_data wins the potential and cfg_rate is still written. tick → SWEEP, idx=0.
- SWEEP: each cycle the output register is empty or being accepted (out_ready): decay pot[idx], write back pot[idx], load out regs {idx, result}, out_valid=1, idx++. At idx=NUM_NEURONS-1 → DRAIN. Stall (no load, no write-back, idx held) while out_valid && !out_ready.
- DRAIN: wait for last handshake; then sweep_done=1 for one cycle, out_valid=0, → IDLE.
- tick while not IDLE: ignored, tick_overrun set; cleared only by RST.
- Decay codes, with e = exponent and m = mantissa: 0001 = unchanged; 0010 = e-1; 0100 = e-2; 1000 = e-3; 0011 = ×0.75; any other code = unchanged.
- ×0.75: s = {1,m}; p = 3·s (26 bits). If p[25]: m' = p[24:2], e' = e. Else m' = p[23:1], e' = e-1. Truncate; no rounding.
- Special values:
  - e = 0 (zero or denormal): output signed zero.
  - e = 255 (Inf/NaN): pass unchanged.
  - Result exponent ≤ 0: flush to signed zero. Sign is always preserved.

## Timing
- Reset: all potentials 0x00000000, all rates RESET_RATE, state IDLE, out_valid=0, out_addr=0, out_data=0, busy=0, sweep_done=0, tick_overrun=0, in_ready=1.
- tick sampled at edge T: busy=1 and in_ready=0 from T+1. out_valid first high after edge T+2.
- With out_ready held high: one output per cycle for NUM_NEURONS cycles. sweep_done is high in the cycle after the last handshake. busy and in_ready return to IDLE values in the same cycle as sweep_done.
- The decay datapath is single-cycle combinational, from the storage read to the out register.
- RST mid-sweep: immediate return to reset state. The partial sweep is not resumed.

## Structure
- Package decay_pkg: decay-code constants (DECAY_HOLD, DECAY_DIV2, DECAY_DIV4, DECAY_DIV8, DECAY_075), FSM state encoding, FP field-position constants.
- Sub-module fp_decay_scale: combinational (in[31:0], rate[3:0]) → out[31:0], containing all arithmetic and special-case handling. Potentials and rates are held in register arrays in the top level.

## Test plan
- cfg neuron 0 = 0x41DED852 with rates 0010/0100/1000/0011 in successive sweeps → out_data 0x415ED852, 0x40DED852, 0x405ED852, 0x41A7223D, each relative to the pre-sweep value.
- Sign and special values: 0xC1DED852 with 1000 → 0xC05ED852; 0x00800000 with 0010 → 0x00000000; 0x7F800000 with any code → 0x7F800000; code 0101 → unchanged.
- NUM_NEURONS=10, out_ready=1, tick at T → out_valid at T+2..T+11 with out_addr 0..9; sweep_done at T+12; busy T+1..T+12.
- Backpressure: out_ready low 3 cycles at out_addr=4 → out_data and out_addr held stable, pot[5] not yet rewritten; sweep_done delayed by 3 cycles.
- upd_valid during sweep → ignored (storage unchanged). Second tick while busy → tick_overrun=1 and no extra sweep. In IDLE, a same-cycle cfg_we and upd_valid to neuron 3 → upd_data stored.
- RST asserted mid-sweep at out_addr=5 → out_valid=0 and busy=0 asynchronously, all potentials 0. A following tick outputs 0x00000000 for every neuron.

Source files
------------

// File: rtl/decay_pkg.sv
// decay_pkg: shared constants for the membrane-potential decay engine.
//   - decay-code constants selecting the decay applied to a neuron
//   - sweep FSM state encoding
//   - IEEE-754 single-precision field positions
package decay_pkg;

  // Decay codes. Any code not listed leaves the potential unchanged.
  localparam logic [3:0] DECAY_HOLD = 4'b0001;  // unchanged
  localparam logic [3:0] DECAY_DIV2 = 4'b0010;  // exponent - 1
  localparam logic [3:0] DECAY_DIV4 = 4'b0100;  // exponent - 2
  localparam logic [3:0] DECAY_DIV8 = 4'b1000;  // exponent - 3
  localparam logic [3:0] DECAY_075  = 4'b0011;  // x0.75, truncated

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FP_SIGN    = 31;
  localparam int FP_EXP_HI  = 30;
  localparam int FP_EXP_LO  = 23;
  localparam int FP_MAN_HI  = 22;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;

endpackage

// File: rtl/fp_decay_scale.sv
// fp_decay_scale: combinational decay of one single-precision potential.
// Ports:
//   in   [31:0]  potential before decay
//   rate [3:0]   decay code (see decay_pkg)
//   out  [31:0]  decayed potential
// Zero/denormal inputs give signed zero, Inf/NaN pass through, and any
// result whose exponent would reach 0 or below is flushed to signed zero.
module fp_decay_scale
  import decay_pkg::*;
(
  input  logic [31:0] in,
  input  logic [3:0]  rate,
  output logic [31:0] out
);

  logic        sgn;
  logic [7:0]  exp_in;
  logic [22:0] man_in;
  logic [23:0] sig;
  logic [25:0] prod;
  logic [7:0]  shift;
  logic        unused_prod_lsb;

  assign sgn    = in[FP_SIGN];
  assign exp_in = in[FP_EXP_HI:FP_EXP_LO];
  assign man_in = in[FP_MAN_HI:0];
  assign sig    = {1'b1, man_in};
  // 3*s as s + 2*s; the lsb is never part of the truncated mantissa.
  assign prod   = {2'b00, sig} + {1'b0, sig, 1'b0};
  assign unused_prod_lsb = prod[0];

  always_comb begin
    shift = 8'd0;
    case (rate)
      DECAY_DIV2: shift = 8'd1;
      DECAY_DIV4: shift = 8'd2;
      DECAY_DIV8: shift = 8'd3;
      default:    shift = 8'd0;
    endcase
  end

  always_comb begin
    out = in;
    if (exp_in == 8'd0) begin
      out = {sgn, 31'd0};
    end else if (exp_in == FP_EXP_MAX) begin
      out = in;
    end else if (rate == DECAY_075) begin
      // Product >= 2.0 keeps the exponent; otherwise renormalise by one.
      if (prod[25]) begin
        out = {sgn, exp_in, prod[24:2]};
      end else if (exp_in == 8'd1) begin
        out = {sgn, 31'd0};
      end else begin
        out = {sgn, exp_in - 8'd1, prod[23:1]};
      end
    end else if (shift != 8'd0) begin
      if (exp_in <= shift) begin
        out = {sgn, 31'd0};
      end else begin
        out = {sgn, exp_in - shift, man_in};
      end
    end
  end

endmodule

// File: rtl/potential_decay_array.sv
// potential_decay_array: multi-neuron membrane-potential decay engine.
// Holds NUM_NEURONS potentials and decay codes. A tick sweeps all neurons in
// index order, decays each, writes it back and streams {index, value} out.
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   tick                     timestep pulse, starts a sweep when idle
//   cfg_we/cfg_addr/cfg_rate/cfg_pot   set rate and potential (idle only)
//   upd_valid/upd_addr/upd_data        adder write-back (idle only)
//   in_ready                 high while idle; writes are ignored otherwise
//   out_valid/out_ready/out_addr/out_data   decayed output stream
//   busy                     sweep in progress
//   sweep_done               one-cycle pulse after the final handshake
//   tick_overrun             sticky: tick seen while not idle
//   dbg_state                current FSM state
// Output handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low,
// out_addr and out_data hold and out_valid stays high.
module potential_decay_array
  import decay_pkg::*;
#(
  parameter int         NUM_NEURONS = 10,
  parameter int         ADDR_W      = $clog2(NUM_NEURONS),
  parameter logic [3:0] RESET_RATE  = 4'b0010
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_rate,
  input  logic [31:0]       cfg_pot,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [31:0]       upd_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_data,
  output logic              busy,
  output logic              sweep_done,
  output logic              tick_overrun,
  output state_t            dbg_state
);

  logic [31:0]       pot_q  [NUM_NEURONS];
  logic [3:0]        rate_q [NUM_NEURONS];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic              last_idx;
  logic              load;
  logic              drain_hs;
  logic [31:0]       decay_out;

  fp_decay_scale u_scale (
    .in   (pot_q[idx_q]),
    .rate (rate_q[idx_q]),
    .out  (decay_out)
  );

  assign last_idx = (idx_q == ADDR_W'(NUM_NEURONS - 1));

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_SWEEP;
      ST_SWEEP: if (load && last_idx) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    in_ready  = (state_q == ST_IDLE);
    dbg_state = state_q;
    // A new result may be loaded whenever the out register is free or
    // being emptied this cycle.
    load      = (state_q == ST_SWEEP) && (!out_valid || out_ready);
    drain_hs  = (state_q == ST_DRAIN) && out_valid && out_ready;
  end

  // Potential and rate storage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        pot_q[i]  <= 32'd0;
        rate_q[i] <= RESET_RATE;
      end
    end else if (state_q == ST_IDLE) begin
      if (cfg_we) begin
        pot_q[cfg_addr]  <= cfg_pot;
        rate_q[cfg_addr] <= cfg_rate;
      end
      // Later assignment: the adder's value wins a same-address collision.
      if (upd_valid) pot_q[upd_addr] <= upd_data;
    end else if (load) begin
      pot_q[idx_q] <= decay_out;
    end
  end

  // Sweep index, output register, status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx_q        <= '0;
      out_valid    <= 1'b0;
      out_addr     <= '0;
      out_data     <= 32'd0;
      sweep_done   <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (state_q == ST_IDLE && tick) idx_q <= '0;
      if (state_q != ST_IDLE && tick) tick_overrun <= 1'b1;
      if (load) begin
        out_valid <= 1'b1;
        out_addr  <= idx_q;
        out_data  <= decay_out;
        if (!last_idx) idx_q <= idx_q + ADDR_W'(1);
      end else if (drain_hs) begin
        out_valid  <= 1'b0;
        sweep_done <= 1'b1;
      end
    end
  end

endmodule
